// File: rtl/idwt_mac_if.sv
// ============================================================================
// Module      : idwt_mac_if
// Description : Stream interface for idwt_mac: coefficient pairs in and
//               reconstructed pairs out, each with valid/ready and pointers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface idwt_mac_if #(
  parameter int PW = 8
);
  logic [15:0]   pixel_input;
  logic          i_valid;
  logic          i_ready;
  logic [PW-1:0] i_row_column_pointer;
  logic [PW-1:0] i_pixel_pointer;
  logic [15:0]   pixel_output;
  logic          o_valid;
  logic          o_ready;
  logic [PW-1:0] o_row_column_pointer;
  logic [PW-1:0] o_pixel_pointer;
  logic          o_row_done;
  logic          o_frame_done;

  modport master (
    output pixel_input, i_valid, i_row_column_pointer, i_pixel_pointer, o_ready,
    input  i_ready, pixel_output, o_valid, o_row_column_pointer, o_pixel_pointer,
           o_row_done, o_frame_done
  );

  modport slave (
    input  pixel_input, i_valid, i_row_column_pointer, i_pixel_pointer, o_ready,
    output i_ready, pixel_output, o_valid, o_row_column_pointer, o_pixel_pointer,
           o_row_done, o_frame_done
  );
endinterface

`default_nettype wire

// File: rtl/idwt_mac.sv
// ============================================================================
// Module      : idwt_mac
// Description : Two-stage inverse DWT butterfly: A = L + H, B = L - H.
//               Define IDWT_SATURATE_EN to clamp results instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idwt_mac #(
  parameter int HEIGHT = 256,
  parameter int WIDTH  = 256
) (
  input  wire logic clk,
  input  wire logic rst,
  idwt_mac_if.slave bus
);

  localparam int PW = $clog2(WIDTH);
  localparam logic [PW-1:0] c_last_pix = PW'(WIDTH - 1);
  localparam logic [PW-1:0] c_last_row = PW'(HEIGHT - 1);

  logic          r_s1_valid;
  logic [8:0]    r_s1_sum;
  logic [8:0]    r_s1_diff;
  logic [PW-1:0] r_s1_row;
  logic [PW-1:0] r_s1_pix;

  logic          r_s2_valid;
  logic [7:0]    r_s2_a;
  logic [7:0]    r_s2_b;
  logic [PW-1:0] r_s2_row;
  logic [PW-1:0] r_s2_pix;
  logic          r_s2_row_done;
  logic          r_s2_frame_done;

  logic          w_s2_adv;
  logic          w_s1_adv;
  logic          w_in_xfer;
  logic [7:0]    w_a;
  logic [7:0]    w_b;

  // A stage may move when empty or when its downstream drains this cycle.
  assign w_s2_adv  = !r_s2_valid || bus.o_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign bus.i_ready = rst && w_s1_adv;
  assign w_in_xfer = bus.i_valid && bus.i_ready;

`ifdef IDWT_SATURATE_EN
  assign w_a = r_s1_sum[8]  ? 8'hFF : r_s1_sum[7:0];
  assign w_b = r_s1_diff[8] ? 8'h00 : r_s1_diff[7:0];
`else
  logic w_unused_msb;
  assign w_unused_msb = r_s1_sum[8] ^ r_s1_diff[8];
  assign w_a = r_s1_sum[7:0];
  assign w_b = r_s1_diff[7:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_diff  <= '0;
      r_s1_row   <= '0;
      r_s1_pix   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_in_xfer;
      if (w_in_xfer) begin
        r_s1_sum  <= {1'b0, bus.pixel_input[15:8]} + {1'b0, bus.pixel_input[7:0]};
        r_s1_diff <= {1'b0, bus.pixel_input[15:8]} - {1'b0, bus.pixel_input[7:0]};
        r_s1_row  <= bus.i_row_column_pointer;
        r_s1_pix  <= bus.i_pixel_pointer;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s2_valid      <= 1'b0;
      r_s2_a          <= '0;
      r_s2_b          <= '0;
      r_s2_row        <= '0;
      r_s2_pix        <= '0;
      r_s2_row_done   <= 1'b0;
      r_s2_frame_done <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_a          <= w_a;
        r_s2_b          <= w_b;
        r_s2_row        <= r_s1_row;
        r_s2_pix        <= r_s1_pix;
        r_s2_row_done   <= (r_s1_pix == c_last_pix);
        r_s2_frame_done <= (r_s1_pix == c_last_pix) && (r_s1_row == c_last_row);
      end
    end
  end

  assign bus.o_valid              = r_s2_valid;
  assign bus.pixel_output         = {r_s2_a, r_s2_b};
  assign bus.o_row_column_pointer = r_s2_row;
  assign bus.o_pixel_pointer      = r_s2_pix;
  // Flags are meaningful only alongside a valid beat.
  assign bus.o_row_done           = r_s2_valid && r_s2_row_done;
  assign bus.o_frame_done         = r_s2_valid && r_s2_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_idwt_mac.sv
// ============================================================================
// Module      : tb_idwt_mac
// Description : Directed self-checking bench for idwt_mac.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idwt_mac;

  localparam int HEIGHT = 256;
  localparam int WIDTH  = 256;
  localparam int PW     = $clog2(WIDTH);

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  idwt_mac_if #(.PW(PW)) bus ();

  idwt_mac #(.HEIGHT(HEIGHT), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one beat, then returns what the output port shows 1, 2 and 3 cycles later.
  task automatic send_one(input logic [7:0] l, input logic [7:0] h,
                          input logic [PW-1:0] row, input logic [PW-1:0] pix,
                          output logic ov_early, output logic [15:0] pout,
                          output logic ov, output logic rd, output logic fd,
                          output logic ov_late);
    @(negedge clk);
    bus.i_valid              = 1'b1;
    bus.pixel_input          = {l, h};
    bus.i_row_column_pointer = row;
    bus.i_pixel_pointer      = pix;
    @(negedge clk);
    bus.i_valid = 1'b0;
    ov_early = bus.o_valid;
    @(negedge clk);
    pout = bus.pixel_output;
    ov   = bus.o_valid;
    rd   = bus.o_row_done;
    fd   = bus.o_frame_done;
    @(negedge clk);
    ov_late = bus.o_valid;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.i_valid = 1'b0;
    bus.pixel_input = '0;
    bus.i_row_column_pointer = '0;
    bus.i_pixel_pointer = '0;
    bus.o_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.o_valid, bus.o_row_done, bus.o_frame_done, bus.i_ready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got v/rd/fd/ir=%b required 0000",
               {bus.o_valid, bus.o_row_done, bus.o_frame_done, bus.i_ready});
    end
    tests_run++;
    if ({bus.pixel_output, bus.o_row_column_pointer, bus.o_pixel_pointer} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got pix=%h row=%0d ptr=%0d required 0",
               bus.pixel_output, bus.o_row_column_pointer, bus.o_pixel_pointer);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.i_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_iready: got %b required 1", bus.i_ready);
    end
  endtask

  task automatic test_basic();
    logic e, v, rd, fd, late;
    logic [15:0] p;
    send_one(8'd100, 8'd20, 8'd3, 8'd5, e, p, v, rd, fd, late);
    tests_run++;
    if ({e, v, late} !== 3'b010) begin
      tests_failed++;
      $display("FAIL basic_latency: got early/on/late=%b required 010", {e, v, late});
    end
    tests_run++;
    if (p !== {8'd120, 8'd80}) begin
      tests_failed++;
      $display("FAIL basic_value: got %h required %h", p, {8'd120, 8'd80});
    end
    tests_run++;
    if ({rd, fd} !== 2'b00) begin
      tests_failed++;
      $display("FAIL basic_flags: got rd/fd=%b required 00", {rd, fd});
    end
  endtask

  task automatic test_overflow();
    logic e, v, rd, fd, late;
    logic [15:0] p;
    logic [15:0] exp1, exp2;
`ifdef IDWT_SATURATE_EN
    exp1 = {8'd255, 8'd100};
    exp2 = {8'd40, 8'd0};
`else
    exp1 = {8'd44, 8'd100};
    exp2 = {8'd40, 8'd236};
`endif
    send_one(8'd200, 8'd100, 8'd0, 8'd0, e, p, v, rd, fd, late);
    tests_run++;
    if (p !== exp1 || v !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_a: got %h v=%b required %h v=1", p, v, exp1);
    end
    send_one(8'd10, 8'd30, 8'd0, 8'd1, e, p, v, rd, fd, late);
    tests_run++;
    if (p !== exp2 || v !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow_b: got %h v=%b required %h v=1", p, v, exp2);
    end
  endtask

  task automatic test_done_flags();
    logic e, v, rd, fd, late;
    logic [15:0] p;
    send_one(8'd1, 8'd1, PW'(HEIGHT-1), PW'(WIDTH-1), e, p, v, rd, fd, late);
    tests_run++;
    if ({v, rd, fd} !== 3'b111) begin
      tests_failed++;
      $display("FAIL frame_done: got v/rd/fd=%b required 111", {v, rd, fd});
    end
    tests_run++;
    if ({bus.o_row_done, bus.o_frame_done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL done_after: got rd/fd=%b required 00",
               {bus.o_row_done, bus.o_frame_done});
    end
    send_one(8'd1, 8'd1, 8'd7, PW'(WIDTH-1), e, p, v, rd, fd, late);
    tests_run++;
    if ({v, rd, fd} !== 3'b110) begin
      tests_failed++;
      $display("FAIL row_done: got v/rd/fd=%b required 110", {v, rd, fd});
    end
    send_one(8'd1, 8'd1, PW'(HEIGHT-1), 8'd0, e, p, v, rd, fd, late);
    tests_run++;
    if ({v, rd, fd} !== 3'b100) begin
      tests_failed++;
      $display("FAIL no_done: got v/rd/fd=%b required 100", {v, rd, fd});
    end
  endtask

  task automatic test_back_to_back();
    int in_idx  = 0;
    int out_idx = 0;
    logic saw_block = 1'b0;
    logic stall_prev = 1'b0;
    logic [15:0] stall_val = '0;
    logic [PW-1:0] stall_ptr = '0;
    logic [15:0] exp_p;
    for (int c = 0; c < 40 && out_idx < 8; c++) begin
      @(negedge clk);
      bus.o_ready = !(c >= 3 && c <= 6);
      if (in_idx < 8) begin
        bus.i_valid              = 1'b1;
        bus.pixel_input          = {8'(10 + 20*in_idx), 8'(in_idx)};
        bus.i_row_column_pointer = PW'(in_idx);
        bus.i_pixel_pointer      = PW'(in_idx + 1);
      end else begin
        bus.i_valid = 1'b0;
      end
      #1;
      if (bus.o_valid) begin
        if (stall_prev) begin
          tests_run++;
          if (bus.pixel_output !== stall_val || bus.o_pixel_pointer !== stall_ptr) begin
            tests_failed++;
            $display("FAIL stall_hold c=%0d: got %h/%0d required %h/%0d", c,
                     bus.pixel_output, bus.o_pixel_pointer, stall_val, stall_ptr);
          end
        end
        if (bus.o_ready) begin
          exp_p = {8'(10 + 21*out_idx), 8'(10 + 19*out_idx)};
          tests_run++;
          if (bus.pixel_output !== exp_p || bus.o_row_column_pointer !== PW'(out_idx)
              || bus.o_pixel_pointer !== PW'(out_idx + 1)) begin
            tests_failed++;
            $display("FAIL b2b_beat%0d: got %h row=%0d ptr=%0d required %h row=%0d ptr=%0d",
                     out_idx, bus.pixel_output, bus.o_row_column_pointer,
                     bus.o_pixel_pointer, exp_p, out_idx, out_idx + 1);
          end
          out_idx++;
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          stall_val  = bus.pixel_output;
          stall_ptr  = bus.o_pixel_pointer;
        end
      end
      if (bus.i_valid && !bus.i_ready) saw_block = 1'b1;
      if (bus.i_valid && bus.i_ready) in_idx++;
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    tests_run++;
    if (out_idx != 8) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d beats required 8", out_idx);
    end
    tests_run++;
    if (saw_block !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_backpressure: got i_ready_blocked=%b required 1", saw_block);
    end
  endtask

  task automatic test_reset_midflight();
    logic e, v, rd, fd, late;
    logic [15:0] p;
    logic stray = 1'b0;
    bus.o_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.i_valid     = 1'b1;
      bus.pixel_input = {8'(50 + k), 8'd5};
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    tests_run++;
    if ({bus.o_valid, bus.i_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL midflight_full: got v/ir=%b required 10", {bus.o_valid, bus.i_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midflight_reset: got o_valid=%b required 0", bus.o_valid);
    end
    rst = 1'b1;
    bus.o_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_valid) stray = 1'b1;
    end
    tests_run++;
    if (stray !== 1'b0) begin
      tests_failed++;
      $display("FAIL midflight_stale: got stale beat=%b required 0", stray);
    end
    send_one(8'd30, 8'd10, 8'd2, 8'd2, e, p, v, rd, fd, late);
    tests_run++;
    if ({e, v, late} !== 3'b010 || p !== {8'd40, 8'd20}) begin
      tests_failed++;
      $display("FAIL post_reset_beat: got e/v/l=%b %h required 010 %h",
               {e, v, late}, p, {8'd40, 8'd20});
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_done_flags();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
